// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Off-chip main-memory model behind the L1 data cache. It
//                accepts one 256-bit line read or write over an enable/ack
//                handshake and answers after a fixed LATENCY.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int LATENCY = 10,   // cycles from capture to ack, 1..255
    parameter int DEPTH   = 512   // number of 256-bit lines, power of two
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] c_LAST_CNT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_cnt;
    logic                 r_write;
    logic [c_IDX_W-1:0]   r_idx;
    logic [255:0]         r_wdata;
    logic                 r_ack;
    logic [255:0]         r_rdata;
    logic [255:0]         r_mem [DEPTH];

    logic                 w_capture;
    logic                 w_access;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_unused_addr;

    // Byte offset and bits above the index field do not select a line;
    // addresses alias modulo the array size.
    assign w_idx         = addr_i[5 +: c_IDX_W];
    assign w_unused_addr = ^{addr_i[4:0], addr_i[31:5+c_IDX_W]};

    // Next-state decode; capture only from IDLE, access on the last WAIT cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == c_LAST_CNT) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and latency counter; reset abandons any in-flight request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_WAIT && !w_access) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Request capture; later input changes are ignored until the next IDLE edge.
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_write <= write_i;
            r_idx   <= w_idx;
            r_wdata <= data_i;
        end
    end

    // Backing store is not reset so preloaded contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (w_access && r_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Registered ack pulse and read data; read data holds until the next read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access && !r_write) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Self-checking bench for data_memory. Two instances: one at
//                LATENCY=10 for functional cases, one at LATENCY=1 for
//                back-to-back throughput with enable held high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int c_LAT_A = 10;
    localparam int c_LAT_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         en_a, wr_a, ack_a;
    logic [31:0]  addr_a;
    logic [255:0] wdata_a, rdata_a;
    logic         en_b, wr_b, ack_b;
    logic [31:0]  addr_b;
    logic [255:0] wdata_b, rdata_b;

    data_memory #(.LATENCY(c_LAT_A), .DEPTH(512)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en_a), .write_i(wr_a),
        .addr_i(addr_a), .data_i(wdata_a), .ack_o(ack_a), .data_o(rdata_a)
    );

    data_memory #(.LATENCY(c_LAT_B), .DEPTH(512)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en_b), .write_i(wr_b),
        .addr_i(addr_b), .data_i(wdata_b), .ack_o(ack_b), .data_o(rdata_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct packed {
        int           cyc;
        logic [255:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    logic [255:0] mdl_a [512];
    logic [255:0] mdl_b [512];
    logic [255:0] last_a = '0;
    logic [255:0] last_b = '0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: every ack must match the oldest pending request in cycle and data.
    always @(negedge clk) begin
        if (!rst && ack_a) begin
            check("a_ack_pending", 256'(q_a.size() != 0), 256'd1);
            if (q_a.size() != 0) begin
                e_a = q_a.pop_front();
                check("a_ack_cyc", 256'(cyc), 256'(e_a.cyc));
                check("a_data", rdata_a, e_a.data);
            end
        end
        if (!rst && ack_b) begin
            check("b_ack_pending", 256'(q_b.size() != 0), 256'd1);
            if (q_b.size() != 0) begin
                e_b = q_b.pop_front();
                check("b_ack_cyc", 256'(cyc), 256'(e_b.cyc));
                check("b_data", rdata_b, e_b.data);
            end
        end
    end

    // One transaction on dut_a; optionally disturbs the inputs after capture.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                          input bit scramble);
        logic [255:0] exp_d;
        bit got;
        int idx;
        @(negedge clk);
        en_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = data;
        idx = int'(addr[13:5]);
        if (wr) begin
            exp_d = last_a;
            mdl_a[idx] = data;
        end else begin
            exp_d = mdl_a[idx];
        end
        last_a = exp_d;
        q_a.push_back(exp_t'{cyc: cyc + 1 + c_LAT_A, data: exp_d});
        if (scramble) begin
            @(negedge clk);
            addr_a  = 32'h0000_1040;
            wdata_a = ~data;
            wr_a    = ~wr;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_a) got = 1'b1;
        end
        check("a_ack_seen", 256'(got), 256'd1);
        en_a = 1'b0;
    endtask

    logic [255:0] c_A5;
    logic [255:0] c_PAT;
    logic [255:0] c_ALIAS;
    logic         op_wr   [8];
    logic [31:0]  op_addr [8];
    logic [255:0] op_data [8];

    initial begin
        bit got;
        int n;
        logic [255:0] exp_d;
        logic [31:0]  w32;

        c_A5    = {32{8'hA5}};
        c_PAT   = {4{64'h0123_4567_89AB_CDEF}};
        c_ALIAS = {8{32'h1357_9BDF}};

        rst = 1'b1;
        en_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
        en_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        check("a_reset_ack", 256'(ack_a), 256'd0);
        check("a_reset_data", rdata_a, 256'd0);
        check("b_reset_ack", 256'(ack_b), 256'd0);
        check("b_reset_data", rdata_b, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // Preload line 3, read it back with full latency
        do_txn(1'b1, 32'h0000_0060, c_A5, 1'b0);
        do_txn(1'b0, 32'h0000_0060, '0, 1'b0);
        // Write line 32, data_o must hold A5 during the write ack, then read via offset
        do_txn(1'b1, 32'h0000_0400, c_PAT, 1'b0);
        do_txn(1'b0, 32'h0000_0410, '0, 1'b0);
        // Aliased write to line 1 with inputs disturbed during WAIT
        do_txn(1'b1, 32'h0000_4020, c_ALIAS, 1'b1);
        do_txn(1'b0, 32'h0000_0020, '0, 1'b0);
        check("a_line1_model", mdl_a[1], c_ALIAS);

        // Reset mid-write: line 5 starts at 0, aborted write must not land
        do_txn(1'b1, 32'h0000_00A0, '0, 1'b0);
        @(negedge clk);
        en_a = 1'b1; wr_a = 1'b1; addr_a = 32'h0000_00A0; wdata_a = {8{32'hDEAD_BEEF}};
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        en_a = 1'b0;
        #1;
        check("a_midwr_rst_ack", 256'(ack_a), 256'd0);
        check("a_midwr_rst_data", rdata_a, 256'd0);
        last_a = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        do_txn(1'b0, 32'h0000_00A0, '0, 1'b0);

        // Asynchronous reset asserted while ack is high clears outputs at once
        do_txn(1'b0, 32'h0000_0400, '0, 1'b0);
        @(negedge clk);
        en_a = 1'b1; wr_a = 1'b0; addr_a = 32'h0000_0060;
        q_a.push_back(exp_t'{cyc: cyc + 1 + c_LAT_A, data: mdl_a[3]});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_a) got = 1'b1;
        end
        check("a_ack_seen_pre_rst", 256'(got), 256'd1);
        #1 rst = 1'b1;
        #1;
        check("a_async_rst_ack", 256'(ack_a), 256'd0);
        check("a_async_rst_data", rdata_a, 256'd0);
        en_a = 1'b0;
        last_a = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // LATENCY=1 stream with enable held: 4 writes then 4 reads, ack every 3rd cycle
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                w32        = 32'hB000_0000 + 32'(k);
                op_wr[k]   = 1'b1;
                op_addr[k] = 32'(k * 32);
                op_data[k] = {8{w32}};
            end else begin
                op_wr[k]   = 1'b0;
                op_addr[k] = 32'((7 - k) * 32);
                op_data[k] = '0;
            end
        end
        @(negedge clk);
        n = cyc;
        for (int k = 0; k < 8; k++) begin
            if (op_wr[k]) begin
                exp_d = last_b;
                mdl_b[int'(op_addr[k][13:5])] = op_data[k];
            end else begin
                exp_d = mdl_b[int'(op_addr[k][13:5])];
            end
            last_b = exp_d;
            q_b.push_back(exp_t'{cyc: n + 1 + c_LAT_B + 3 * k, data: exp_d});
        end
        en_b = 1'b1; wr_b = op_wr[0]; addr_b = op_addr[0]; wdata_b = op_data[0];
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (ack_b) got = 1'b1;
            end
            check("b_ack_seen", 256'(got), 256'd1);
            if (k < 7) begin
                wr_b = op_wr[k+1]; addr_b = op_addr[k+1]; wdata_b = op_data[k+1];
            end else begin
                en_b = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        check("a_queue_empty", 256'(q_a.size()), 256'd0);
        check("b_queue_empty", 256'(q_b.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/data_memory.md
# data_memory

Off-chip main-memory model sitting directly downstream of the L1 data-cache controller: it accepts one 256-bit cache-line read or write request at a time over the enable/ack interface and answers after a fixed, parameterised latency. It is the memory port the CPU top exports (`mem_*`) and is instantiated beside the CPU in the testbench. It holds the backing store the cache refills from and writes back to.

## Interface
- `LATENCY`, 10, cycles from request capture to ack; legal range 1..255
- `DEPTH`, 512, number of 256-bit lines; power of two
- `clk_i`  input  1  clock, all state updates on rising edge
- `rst_i`  input  1  reset, asynchronous, active-high
- `enable_i`  input  1  request valid; held by requester until `ack_o`
- `write_i`  input  1  1 = line write, 0 = line read; valid with `enable_i`
- `addr_i`  input  32  byte address; line index = `addr_i[5 +: log2(DEPTH)]`
- `data_i`  input  256  write line data; valid with `enable_i` when `write_i`=1
- `ack_o`  output  1  one-cycle completion pulse, registered
- `data_o`  output  256  read line data, valid while `ack_o`=1, registered

## Operation
- Storage: array of `DEPTH` x 256 bits; contents not cleared by reset (bench preloads).
- Address: `addr_i[4:0]` ignored; bits above the index field ignored (addresses alias modulo `DEPTH`*32 bytes).
- FSM states IDLE, WAIT, ACK; 8-bit counter `cnt`.
- IDLE: if `enable_i`=1 at an edge, capture `addr_i`, `write_i`, `data_i` into internal registers, `cnt`<=0, go WAIT. Otherwise stay.
- WAIT: if `cnt`==`LATENCY`-1, perform the access using captured values and go ACK; else `cnt`<=`cnt`+1. Inputs are not re-sampled in WAIT; changes to `addr_i`/`data_i`/`write_i` after capture have no effect.
- Access: write -> array[index]<=captured data, `data_o` unchanged; read -> `data_o`<=array[index].
- ACK: `ack_o`=1 for this single cycle; next edge unconditionally returns to IDLE.
- `enable_i` is ignored in WAIT and ACK; a new request is accepted only by an IDLE edge. A requester still holding `enable_i` in the cycle after ack starts a new transaction (the cache controller drops it on ack).
- Reset (any time): state IDLE, `cnt`=0, `ack_o`=0, `data_o`=0; an in-flight write that has not reached the access edge is discarded, array untouched.

## Timing
- Edge E0: IDLE samples `enable_i`=1 -> WAIT. Access edge E`LATENCY`. `ack_o`=1 from E`LATENCY` to E`LATENCY`+1. IDLE again after E`LATENCY`+1; earliest next capture at E`LATENCY`+2.
- Throughput: one transaction per `LATENCY`+2 cycles when back-to-back.
- `LATENCY`=1: capture at E0, access and ack at E1.
- Read-after-write to the same line returns the written data (write commits at the access edge, before the next capture).
- `data_o` holds the last read line until the next read access or reset.
- `ack_o` never asserted for two consecutive cycles; never asserted without a preceding capture.

## Test plan
- Reset: assert `rst_i` asynchronously mid-cycle -> `ack_o`=0, `data_o`=0 immediately, before the next edge; FSM in IDLE after deassert.
- Read latency: preload line 3 = 256'hA5..A5, request read `addr_i`=32'h60 at E0 -> `ack_o` high exactly in cycle E10..E11, `data_o`=A5..A5, no ack on any other cycle.
- Write then read: write 256'h0123_..._CDEF to `addr_i`=32'h0000_0400 (line 32), then read `addr_i`=32'h0000_0410 -> second ack returns 256'h0123_..._CDEF; `data_o` unchanged during the write ack.
- Aliasing/ignored inputs: write line via `addr_i`=32'h0000_4020 (DEPTH=512 -> line 1); during WAIT change `addr_i`/`data_i` -> read of 32'h20 returns originally captured data.
- Reset mid-write: start write to line 5 (old value 0), assert `rst_i` at cnt=4 -> no ack; subsequent read of line 5 returns 0.
- Back-to-back with `LATENCY`=1 and `enable_i` held high -> acks every 3rd cycle, each completing a distinct transaction.
